// File: rtl/pokey_ctrl_responder.sv
// Controller-side stand-in for the POKEY keypad and paddle interface: answers the
// key scan on kr1_L and emulates paddle RC charge time on pot_scan_2.
module pokey_ctrl_responder #(
    parameter int HOLD_SCANS = 2,
    parameter int POT_MAX    = 228
) (
    input  logic       o2,
    input  logic       rst,
    input  logic [3:0] key_scan_L,
    output logic       kr1_L,
    input  logic [3:0] key_code,
    input  logic       key_req,
    output logic       key_busy,
    input  logic [1:0] pot_rel,
    input  logic       pot_tick,
    input  logic [7:0] pot_val0,
    input  logic [7:0] pot_val1,
    output logic [1:0] pot_scan_2,
    input  logic [1:0] btn,
    output logic [1:0] side_but
);
    typedef enum logic [1:0] {KEY_IDLE, KEY_ARM, KEY_HOLD, KEY_RELEASE} key_state_t;
    typedef enum logic [1:0] {POT_DUMP, POT_CHARGE, POT_DONE} pot_state_t;

    localparam logic [3:0] HOLD_LIMIT = 4'(HOLD_SCANS);
    localparam logic [8:0] POT_LIMIT  = 9'(POT_MAX);

    logic [3:0] scan;
    logic [3:0] scan_prev_reg;
    logic       wrap;
    key_state_t key_state_reg, key_state_next;
    logic [3:0] code_reg, code_next;
    logic [3:0] wrap_cnt_reg, wrap_cnt_next;
    logic       kr1_reg, kr1_next;
    logic [1:0] side_reg;
    logic [7:0] pot_val [2];

    assign scan = ~key_scan_L;
    // A wrap marks the boundary between two complete 16-key scans.
    assign wrap = (scan_prev_reg == 4'd15) && (scan == 4'd0);

    always_ff @(posedge o2) begin
        if (rst) begin
            scan_prev_reg <= 4'd0;
            key_state_reg <= KEY_IDLE;
            code_reg      <= 4'd0;
            wrap_cnt_reg  <= 4'd0;
            kr1_reg       <= 1'b1;
            side_reg      <= 2'b11;
        end else begin
            scan_prev_reg <= scan;
            key_state_reg <= key_state_next;
            code_reg      <= code_next;
            wrap_cnt_reg  <= wrap_cnt_next;
            kr1_reg       <= kr1_next;
            side_reg      <= ~btn;
        end
    end

    always_comb begin
        key_state_next = key_state_reg;
        code_next      = code_reg;
        wrap_cnt_next  = wrap_cnt_reg;
        case (key_state_reg)
            KEY_IDLE: begin
                if (key_req) begin
                    code_next      = key_code;
                    key_state_next = KEY_ARM;
                end
            end
            KEY_ARM: begin
                // Wait for a scan boundary so the press covers only whole scans.
                if (wrap) begin
                    wrap_cnt_next  = 4'd0;
                    key_state_next = KEY_HOLD;
                end
            end
            KEY_HOLD: begin
                if (wrap) begin
                    wrap_cnt_next = wrap_cnt_reg + 4'd1;
                    if (wrap_cnt_reg + 4'd1 == HOLD_LIMIT) begin
                        key_state_next = KEY_RELEASE;
                    end
                end
            end
            KEY_RELEASE: begin
                if (wrap) begin
                    key_state_next = KEY_IDLE;
                end
            end
            default: key_state_next = KEY_IDLE;
        endcase
        kr1_next = !((key_state_reg == KEY_HOLD) && (scan == code_reg));
    end

    assign kr1_L    = kr1_reg;
    assign key_busy = (key_state_reg != KEY_IDLE);
    assign side_but = side_reg;

    assign pot_val[0] = pot_val0;
    assign pot_val[1] = pot_val1;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_pot
            pot_state_t state_reg, state_next;
            logic [7:0] cnt_reg, cnt_next;
            logic [7:0] tgt_reg, tgt_next;
            logic       scan_reg;

            always_comb begin
                state_next = state_reg;
                cnt_next   = cnt_reg;
                tgt_next   = tgt_reg;
                // A held-low release dumps the capacitor from any state, even on a tick.
                if (!pot_rel[gi]) begin
                    state_next = POT_DUMP;
                    cnt_next   = 8'd0;
                end else begin
                    case (state_reg)
                        POT_DUMP: begin
                            tgt_next   = pot_val[gi];
                            state_next = (pot_val[gi] == 8'd0) ? POT_DONE : POT_CHARGE;
                        end
                        POT_CHARGE: begin
                            if (pot_tick) begin
                                if (cnt_reg != 8'hFF) begin
                                    cnt_next = cnt_reg + 8'd1;
                                end
                                if (({1'b0, tgt_reg} < POT_LIMIT) &&
                                    ({1'b0, cnt_reg} + 9'd1 == {1'b0, tgt_reg})) begin
                                    state_next = POT_DONE;
                                end
                            end
                        end
                        POT_DONE: state_next = POT_DONE;
                        default:  state_next = POT_DUMP;
                    endcase
                end
            end

            always_ff @(posedge o2) begin
                if (rst) begin
                    state_reg <= POT_DUMP;
                    cnt_reg   <= 8'd0;
                    tgt_reg   <= 8'd0;
                    scan_reg  <= 1'b0;
                end else begin
                    state_reg <= state_next;
                    cnt_reg   <= cnt_next;
                    tgt_reg   <= tgt_next;
                    scan_reg  <= (state_next == POT_DONE);
                end
            end

            assign pot_scan_2[gi] = scan_reg;
        end
    endgenerate
endmodule

// File: tb/tb_pokey_ctrl_responder.sv
// Trace-driven bench: builds a stimulus trace, derives expected outputs from scan
// wraps and tick counts, and checks the DUT through a scoreboard queue.
module tb_pokey_ctrl_responder;
    localparam int HOLD = 2;
    localparam int PMAX = 228;
    localparam int NMAX = 6000;

    logic       o2 = 1'b0;
    logic       rst;
    logic [3:0] key_scan_L;
    logic       kr1_L;
    logic [3:0] key_code;
    logic       key_req;
    logic       key_busy;
    logic [1:0] pot_rel;
    logic       pot_tick;
    logic [7:0] pot_val0;
    logic [7:0] pot_val1;
    logic [1:0] pot_scan_2;
    logic [1:0] btn;
    logic [1:0] side_but;

    always #5 o2 = ~o2;

    pokey_ctrl_responder #(.HOLD_SCANS(HOLD), .POT_MAX(PMAX)) dut (
        .o2(o2), .rst(rst), .key_scan_L(key_scan_L), .kr1_L(kr1_L),
        .key_code(key_code), .key_req(key_req), .key_busy(key_busy),
        .pot_rel(pot_rel), .pot_tick(pot_tick), .pot_val0(pot_val0),
        .pot_val1(pot_val1), .pot_scan_2(pot_scan_2), .btn(btn), .side_but(side_but)
    );

    // Stimulus trace, one entry per clock cycle
    bit       t_rst  [NMAX];
    bit [3:0] t_scan [NMAX];
    bit       t_req  [NMAX];
    bit [3:0] t_code [NMAX];
    bit [1:0] t_rel  [NMAX];
    bit       t_tick [NMAX];
    bit [7:0] t_v0   [NMAX];
    bit [7:0] t_v1   [NMAX];
    bit [1:0] t_btn  [NMAX];
    // Expected outputs visible just after the clock edge ending each cycle
    bit       e_kr1  [NMAX];
    bit       e_busy [NMAX];
    bit [1:0] e_pot  [NMAX];
    bit [1:0] e_side [NMAX];
    int n_cyc = 0;

    bit       c_rst = 0;
    bit [3:0] c_scan = 0;
    bit       c_req = 0;
    bit [3:0] c_code = 0;
    bit [1:0] c_rel = 0;
    bit       c_tick = 0;
    bit [7:0] c_v0 = 0;
    bit [7:0] c_v1 = 0;
    bit [1:0] c_btn = 0;

    typedef struct {
        bit       kr1;
        bit       busy;
        bit [1:0] pot;
        bit [1:0] side;
        int       cyc;
    } exp_t;
    exp_t sb_q[$];

    int errors = 0;
    int checks = 0;

    task automatic commit(input int reps = 1);
        repeat (reps) begin
            if (n_cyc < NMAX) begin
                t_rst[n_cyc]  = c_rst;  t_scan[n_cyc] = c_scan; t_req[n_cyc] = c_req;
                t_code[n_cyc] = c_code; t_rel[n_cyc]  = c_rel;  t_tick[n_cyc] = c_tick;
                t_v0[n_cyc]   = c_v0;   t_v1[n_cyc]   = c_v1;   t_btn[n_cyc] = c_btn;
                n_cyc++;
            end
            c_req  = 1'b0;
            c_tick = 1'b0;
            c_scan = c_scan + 4'd1;
        end
    endtask

    function automatic bit [7:0] pick_val();
        case ($urandom_range(0, 7))
            0:       return 8'd0;
            1:       return 8'd1;
            2:       return 8'd227;
            3:       return 8'd228;
            4:       return 8'd255;
            default: return 8'($urandom_range(1, 20));
        endcase
    endfunction

    function automatic bit wrap_at(input int k);
        int prev;
        if (t_rst[k]) return 1'b0;
        prev = (k == 0 || t_rst[k-1]) ? 0 : int'(t_scan[k-1]);
        return (prev == 15) && (t_scan[k] == 4'd0);
    endfunction

    task automatic build_trace();
        // Reset for two cycles in the middle of a HOLD of key 5, buttons = 01
        c_btn = 2'b01; c_rst = 1'b1; commit(3);
        c_rst = 1'b0; commit(2);
        c_req = 1'b1; c_code = 4'd5; commit();
        commit(24);
        c_rst = 1'b1; commit(2);
        c_rst = 1'b0; commit(20);
        // Clean press of key 5, then a request for key 9 while busy
        c_req = 1'b1; c_code = 4'd5; commit();
        commit(20);
        c_req = 1'b1; c_code = 4'd9; commit();
        commit(80);
        // Pot count of 3 with ticks every 4 cycles, then pot1 with value 0
        c_v0 = 8'd3; c_v1 = 8'd0; c_rel = 2'b01; commit();
        repeat (5) begin commit(3); c_tick = 1'b1; commit(); end
        c_rel = 2'b11; commit(5);
        c_rel = 2'b00; commit(2);
        // Value at the never-trip threshold with 300 ticks
        c_v0 = 8'd228; c_rel = 2'b01; commit();
        repeat (300) begin c_tick = 1'b1; commit(); end
        c_rel = 2'b00; commit(2);
        // Dump after 2 of 3 ticks, then a fresh release must restart the count
        c_v0 = 8'd3; c_rel = 2'b01; commit();
        repeat (2) begin commit(2); c_tick = 1'b1; commit(); end
        c_rel = 2'b00; commit(2);
        c_rel = 2'b01; commit();
        repeat (4) begin commit(2); c_tick = 1'b1; commit(); end
        c_rel = 2'b00; commit(2);
        // Release falls on the completing tick
        c_rel = 2'b01; commit();
        repeat (2) begin commit(); c_tick = 1'b1; commit(); end
        commit();
        c_tick = 1'b1; c_rel = 2'b00; commit();
        commit(3);
        // Randomised mix of everything
        repeat (2000) begin
            c_rst  = ($urandom_range(0, 499) == 0);
            c_req  = ($urandom_range(0, 19) == 0);
            c_code = 4'($urandom);
            c_tick = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 39) == 0) c_rel[0] = ~c_rel[0];
            if ($urandom_range(0, 39) == 0) c_rel[1] = ~c_rel[1];
            if ($urandom_range(0, 7) == 0) c_v0 = pick_val();
            c_v1  = pick_val();
            c_btn = 2'($urandom);
            if ($urandom_range(0, 99) == 0) c_scan = 4'($urandom);
            commit();
        end
        c_rst = 1'b0;
    endtask

    task automatic build_expected();
        int c, t, nw, w1, wh, endc, s, k, nt, done, tgt;
        bit [3:0] code;
        for (int m = 0; m < n_cyc; m++) begin
            e_kr1[m]  = 1'b1;
            e_busy[m] = 1'b0;
            e_pot[m]  = 2'b00;
            e_side[m] = t_rst[m] ? 2'b11 : ~t_btn[m];
        end
        // Key press: busy from acceptance to the (HOLD+2)-th wrap, pressed between
        // the 1st and (HOLD+1)-th wraps; a reset cuts the press short.
        c = 0;
        while (c < n_cyc) begin
            if (t_rst[c] || !t_req[c]) begin
                c++;
                continue;
            end
            t = c; code = t_code[c]; nw = 0; w1 = -1; wh = -1; endc = n_cyc;
            for (int m = t + 1; m < n_cyc; m++) begin
                if (t_rst[m]) begin endc = m; break; end
                if (wrap_at(m)) begin
                    nw++;
                    if (nw == 1) w1 = m;
                    if (nw == HOLD + 1) wh = m;
                    if (nw == HOLD + 2) begin endc = m; break; end
                end
            end
            for (int m = t; m < endc; m++) e_busy[m] = 1'b1;
            if (w1 >= 0) begin
                int last;
                last = (wh >= 0) ? wh : endc - 1;
                for (int m = w1 + 1; m <= last; m++)
                    if (t_scan[m] == code) e_kr1[m] = 1'b0;
            end
            $display("key press code=%0d accepted cycle %0d busy until cycle %0d", code, t, endc);
            c = endc + 1;
        end
        // Pots: each release counts ticks until the target, while still released.
        for (int i = 0; i < 2; i++) begin
            c = 0;
            while (c < n_cyc) begin
                if (t_rst[c] || !t_rel[c][i]) begin
                    c++;
                    continue;
                end
                s = c;
                tgt = (i == 0) ? int'(t_v0[s]) : int'(t_v1[s]);
                done = (tgt == 0) ? s : -1;
                nt = 0;
                k = s + 1;
                while (k < n_cyc && !t_rst[k] && t_rel[k][i]) begin
                    if (done < 0 && t_tick[k] && tgt < PMAX) begin
                        nt++;
                        if (nt == tgt) done = k;
                    end
                    k++;
                end
                if (done >= 0)
                    for (int m = done; m < k; m++) e_pot[m][i] = 1'b1;
                $display("pot%0d release cycle %0d target=%0d tripped at cycle %0d", i, s, tgt, done);
                c = k;
            end
        end
    endtask

    function automatic void chk(input string name, input int cyc,
                                input logic [1:0] act, input logic [1:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s cycle %0d: got %b, want %b", name, cyc, act, want);
        end
    endfunction

    // Monitor: compares each presented output set against the queued expectation
    initial begin
        forever begin
            @(negedge o2);
            if (sb_q.size() > 0) begin
                exp_t e;
                e = sb_q.pop_front();
                chk("kr1_L", e.cyc, {1'b0, kr1_L}, {1'b0, e.kr1});
                chk("key_busy", e.cyc, {1'b0, key_busy}, {1'b0, e.busy});
                chk("pot_scan_2", e.cyc, pot_scan_2, e.pot);
                chk("side_but", e.cyc, side_but, e.side);
            end
        end
    end

    initial begin
        build_trace();
        build_expected();
        for (int c = 0; c < n_cyc; c++) begin
            exp_t e;
            rst        = t_rst[c];
            key_scan_L = ~t_scan[c];
            key_req    = t_req[c];
            key_code   = t_code[c];
            pot_rel    = t_rel[c];
            pot_tick   = t_tick[c];
            pot_val0   = t_v0[c];
            pot_val1   = t_v1[c];
            btn        = t_btn[c];
            e.kr1 = e_kr1[c]; e.busy = e_busy[c]; e.pot = e_pot[c]; e.side = e_side[c]; e.cyc = c;
            sb_q.push_back(e);
            @(posedge o2);
            #1;
        end
        for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(negedge o2);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
